bpu_update_scheduler: RTL and testbench

- Sits between the Memory-stage branch-resolution outputs and the branch predictor tables.
- Those tables are rebuilt as single-write-port memories, so they no longer have bulk reset or two write ports.
- The block clears every BHT/BTB entry after reset with a sequential sweep.
- It then buffers up to two resolved-branch updates per cycle in a FIFO and drains them to the single write port at one per cycle, in program order.

---
 rtl/bpu_update_scheduler_if.sv | 38 +++
 rtl/bpu_update_scheduler.sv | 113 +++++++++++
 tb/tb_bpu_update_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bpu_update_scheduler_if.sv
// Branch-resolution update bus between the Memory stage, the update scheduler
// and the single-write-port predictor tables.
interface bpu_update_scheduler_if #(
    parameter int PC_W  = 9,
    parameter int IDX_W = 6
);
    logic             m_valid1;
    logic             m_taken1;
    logic [PC_W-1:0]  m_pc1;
    logic [PC_W-1:0]  m_target1;
    logic             m_valid2;
    logic             m_taken2;
    logic [PC_W-1:0]  m_pc2;
    logic [PC_W-1:0]  m_target2;

    logic             q_full;
    logic             init_busy;
    logic             upd_dropped;
    logic             wr_en;
    logic             wr_clear;
    logic [IDX_W-1:0] wr_index;
    logic             wr_taken;
    logic [PC_W-1:0]  wr_target;

    modport master (
        output m_valid1, m_taken1, m_pc1, m_target1,
        output m_valid2, m_taken2, m_pc2, m_target2,
        input  q_full, init_busy, upd_dropped,
        input  wr_en, wr_clear, wr_index, wr_taken, wr_target
    );

    modport slave (
        input  m_valid1, m_taken1, m_pc1, m_target1,
        input  m_valid2, m_taken2, m_pc2, m_target2,
        output q_full, init_busy, upd_dropped,
        output wr_en, wr_clear, wr_index, wr_taken, wr_target
    );
endinterface

// File: rtl/bpu_update_scheduler.sv
// Clears the predictor tables after reset, then serialises up to two resolved
// branch updates per cycle onto the single table write port in program order.
module bpu_update_scheduler #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 9,
    parameter int IDX_W = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    bpu_update_scheduler_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    typedef struct packed {
        logic             taken;
        logic [IDX_W-1:0] index;
        logic [PC_W-1:0]  target;
    } entry_t;

    state_t           state;
    logic [IDX_W-1:0] init_cnt;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    entry_t           mem [DEPTH];

    entry_t           slot1, slot2, first_ent, head;
    logic             pop, drop;
    logic [CNT_W-1:0] free;
    logic [1:0]       n_req, n_acc;

    // Only the table index bits of the PC address the predictor.
    logic unused_pc_hi;
    assign unused_pc_hi = ^{bus.m_pc1, bus.m_pc2};

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        slot1     = '{taken: bus.m_taken1, index: bus.m_pc1[IDX_W-1:0], target: bus.m_target1};
        slot2     = '{taken: bus.m_taken2, index: bus.m_pc2[IDX_W-1:0], target: bus.m_target2};
        first_ent = bus.m_valid1 ? slot1 : slot2;
        head      = mem[rd_ptr];
        pop       = (state == S_RUN) && (count != '0);
        free      = CNT_W'(DEPTH) - count + CNT_W'(pop);
        n_req     = {1'b0, bus.m_valid1} + {1'b0, bus.m_valid2};
        n_acc     = 2'd0;
        if (n_req == 2'd2 && free >= CNT_W'(2))
            n_acc = 2'd2;
        else if (n_req != 2'd0 && free != '0)
            n_acc = 2'd1;
        drop      = (n_acc != n_req);
    end

    assign bus.q_full = (count > CNT_W'(DEPTH - 2));

    // NOTE: the payload array is deliberately not reset; count/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (n_acc != 2'd0)
            mem[wr_ptr] <= first_ent;
        if (n_acc == 2'd2)
            mem[wr_ptr + PTR_W'(1)] <= slot2;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_INIT;
            init_cnt        <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            bus.init_busy   <= 1'b1;
            bus.upd_dropped <= 1'b0;
            bus.wr_en       <= 1'b0;
            bus.wr_clear    <= 1'b0;
            bus.wr_index    <= '0;
            bus.wr_taken    <= 1'b0;
            bus.wr_target   <= '0;
        end else begin
            rd_ptr          <= rd_ptr + PTR_W'(pop);
            wr_ptr          <= wr_ptr + PTR_W'(n_acc);
            count           <= count + CNT_W'(n_acc) - CNT_W'(pop);
            bus.upd_dropped <= drop;

            case (state)
                S_INIT: begin
                    bus.init_busy <= 1'b1;
                    bus.wr_en     <= 1'b1;
                    bus.wr_clear  <= 1'b1;
                    bus.wr_index  <= init_cnt;
                    bus.wr_taken  <= 1'b0;
                    bus.wr_target <= '0;
                    init_cnt      <= init_cnt + IDX_W'(1);
                    if (init_cnt == LAST_IDX)
                        state <= S_RUN;
                end
                S_RUN: begin
                    bus.init_busy <= 1'b0;
                    bus.wr_en     <= pop;
                    if (pop) begin
                        bus.wr_clear  <= 1'b0;
                        bus.wr_index  <= head.index;
                        bus.wr_taken  <= head.taken;
                        bus.wr_target <= head.target;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_bpu_update_scheduler.sv
// Self-checking bench: a queue-based reference model predicts the write port
// every cycle under directed and randomised dual-slot update traffic.
module tb_bpu_update_scheduler;
    localparam int DEPTH = 4;
    localparam int PC_W  = 9;
    localparam int IDX_W = 6;
    localparam int NENT  = 1 << IDX_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bpu_update_scheduler_if #(.PC_W(PC_W), .IDX_W(IDX_W)) bus ();

    bpu_update_scheduler #(.DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic             taken;
        logic [IDX_W-1:0] idx;
        logic [PC_W-1:0]  tgt;
    } upd_t;

    upd_t             q[$];
    int               init_idx;
    logic             e_en, e_clr, e_tk, e_busy, e_drop;
    logic [IDX_W-1:0] e_idx;
    logic [PC_W-1:0]  e_tgt;

    task automatic model_reset();
        q.delete();
        init_idx = 0;
        e_en = 0; e_clr = 0; e_tk = 0; e_busy = 1; e_drop = 0;
        e_idx = '0; e_tgt = '0;
    endtask

    // Apply one cycle of inputs, advance the model, compare every output at the negedge.
    task automatic step(input logic v1, input logic t1, input logic [PC_W-1:0] p1, input logic [PC_W-1:0] g1,
                        input logic v2, input logic t2, input logic [PC_W-1:0] p2, input logic [PC_W-1:0] g2);
        upd_t reqs[$];
        upd_t u;
        int   free;
        bus.m_valid1 = v1; bus.m_taken1 = t1; bus.m_pc1 = p1; bus.m_target1 = g1;
        bus.m_valid2 = v2; bus.m_taken2 = t2; bus.m_pc2 = p2; bus.m_target2 = g2;
        @(posedge clk);
        if (init_idx < NENT) begin
            e_en = 1; e_clr = 1; e_idx = IDX_W'(init_idx); e_tk = 0; e_tgt = '0; e_busy = 1;
            init_idx++;
        end else begin
            e_busy = 0;
            if (q.size() > 0) begin
                u = q.pop_front();
                e_en = 1; e_clr = 0; e_idx = u.idx; e_tk = u.taken; e_tgt = u.tgt;
            end else begin
                e_en = 0;
            end
        end
        free = DEPTH - q.size();
        if (v1) reqs.push_back('{taken: t1, idx: p1[IDX_W-1:0], tgt: g1});
        if (v2) reqs.push_back('{taken: t2, idx: p2[IDX_W-1:0], tgt: g2});
        e_drop = (reqs.size() > free);
        for (int i = 0; i < reqs.size() && i < free; i++) q.push_back(reqs[i]);
        @(negedge clk);
        vectors += 8;
        if (bus.wr_en !== e_en) begin miscompares++; $display("FAIL wr_en t=%0t got %b exp %b", $time, bus.wr_en, e_en); end
        if (bus.wr_clear !== e_clr) begin miscompares++; $display("FAIL wr_clear t=%0t got %b exp %b", $time, bus.wr_clear, e_clr); end
        if (bus.wr_index !== e_idx) begin miscompares++; $display("FAIL wr_index t=%0t got %h exp %h", $time, bus.wr_index, e_idx); end
        if (bus.wr_taken !== e_tk) begin miscompares++; $display("FAIL wr_taken t=%0t got %b exp %b", $time, bus.wr_taken, e_tk); end
        if (bus.wr_target !== e_tgt) begin miscompares++; $display("FAIL wr_target t=%0t got %h exp %h", $time, bus.wr_target, e_tgt); end
        if (bus.init_busy !== e_busy) begin miscompares++; $display("FAIL init_busy t=%0t got %b exp %b", $time, bus.init_busy, e_busy); end
        if (bus.upd_dropped !== e_drop) begin miscompares++; $display("FAIL upd_dropped t=%0t got %b exp %b", $time, bus.upd_dropped, e_drop); end
        if (bus.q_full !== (q.size() > DEPTH - 2)) begin
            miscompares++; $display("FAIL q_full t=%0t got %b exp %b", $time, bus.q_full, q.size() > DEPTH - 2);
        end
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.m_valid1 = 0; bus.m_taken1 = 0; bus.m_pc1 = '0; bus.m_target1 = '0;
        bus.m_valid2 = 0; bus.m_taken2 = 0; bus.m_pc2 = '0; bus.m_target2 = '0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.wr_en, bus.wr_clear, bus.wr_taken, bus.upd_dropped, bus.q_full, bus.init_busy} !== 6'b000001) begin
            miscompares++;
            $display("FAIL reset_flags got en=%b clr=%b tk=%b drop=%b full=%b busy=%b exp 000001",
                     bus.wr_en, bus.wr_clear, bus.wr_taken, bus.upd_dropped, bus.q_full, bus.init_busy);
        end
        vectors++;
        if (bus.wr_index !== '0 || bus.wr_target !== '0) begin
            miscompares++; $display("FAIL reset_fields got idx=%h tgt=%h exp 0", bus.wr_index, bus.wr_target);
        end
        reset = 1'b1;
    endtask

    task automatic test_init_sweep();
        for (int i = 0; i < NENT; i++) begin
            idle();
            vectors++;
            if (!(bus.wr_en && bus.wr_clear && bus.wr_index == IDX_W'(i))) begin
                miscompares++; $display("FAIL sweep_%0d got en=%b clr=%b idx=%0d", i, bus.wr_en, bus.wr_clear, bus.wr_index);
            end
        end
        idle();
        vectors++;
        if (bus.init_busy !== 1'b0 || bus.wr_en !== 1'b0) begin
            miscompares++; $display("FAIL sweep_end got busy=%b en=%b exp 0 0", bus.init_busy, bus.wr_en);
        end
    endtask

    task automatic test_single();
        step(1, 1, 9'h045, 9'h010, 0, 0, '0, '0);
        idle();
        vectors++;
        if ({bus.wr_en, bus.wr_clear, bus.wr_index, bus.wr_taken, bus.wr_target} !== {1'b1, 1'b0, 6'h05, 1'b1, 9'h010}) begin
            miscompares++; $display("FAIL single_write got en=%b clr=%b idx=%h tk=%b tgt=%h exp 1 0 05 1 010",
                                    bus.wr_en, bus.wr_clear, bus.wr_index, bus.wr_taken, bus.wr_target);
        end
        idle();
        vectors++;
        if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL single_after got wr_en=%b exp 0", bus.wr_en); end
    endtask

    task automatic test_dual();
        step(1, 0, 9'h003, 9'h0aa, 1, 1, 9'h007, 9'h020);
        idle();
        vectors++;
        if ({bus.wr_en, bus.wr_index, bus.wr_taken} !== {1'b1, 6'h03, 1'b0}) begin
            miscompares++; $display("FAIL dual_first got en=%b idx=%h tk=%b exp 1 03 0", bus.wr_en, bus.wr_index, bus.wr_taken);
        end
        idle();
        vectors++;
        if ({bus.wr_en, bus.wr_index, bus.wr_taken, bus.wr_target} !== {1'b1, 6'h07, 1'b1, 9'h020}) begin
            miscompares++; $display("FAIL dual_second got en=%b idx=%h tk=%b tgt=%h exp 1 07 1 020",
                                    bus.wr_en, bus.wr_index, bus.wr_taken, bus.wr_target);
        end
        idle();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            step(1, i[0], PC_W'(16 + 2 * i), PC_W'(100 + i), 1, ~i[0], PC_W'(17 + 2 * i), PC_W'(200 + i));
            if (i == 1) begin
                vectors++;
                if (bus.q_full !== 1'b1) begin miscompares++; $display("FAIL fill_qfull got %b exp 1", bus.q_full); end
            end
            if (i == 2) begin
                vectors++;
                if (bus.upd_dropped !== 1'b0) begin miscompares++; $display("FAIL fill_third got drop=%b exp 0", bus.upd_dropped); end
            end
            if (i == 3) begin
                vectors++;
                if (bus.upd_dropped !== 1'b1) begin miscompares++; $display("FAIL fill_fourth got drop=%b exp 1", bus.upd_dropped); end
            end
        end
        idle();
        vectors++;
        if (bus.upd_dropped !== 1'b0) begin miscompares++; $display("FAIL fill_pulse got drop=%b exp 0", bus.upd_dropped); end
        repeat (5) idle();
    endtask

    task automatic test_init_enqueue();
        apply_reset();
        for (int i = 0; i < NENT; i++) begin
            if (i == 10) step(0, 0, '0, '0, 1, 1, 9'h13a, 9'h0f5);
            else         idle();
        end
        idle();
        vectors++;
        if ({bus.wr_en, bus.wr_clear, bus.wr_index, bus.wr_target} !== {1'b1, 1'b0, 6'h3a, 9'h0f5}) begin
            miscompares++; $display("FAIL init_enqueue got en=%b clr=%b idx=%h tgt=%h exp 1 0 3a 0f5",
                                    bus.wr_en, bus.wr_clear, bus.wr_index, bus.wr_target);
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, 1'($urandom), PC_W'($urandom), PC_W'($urandom),
                 $urandom_range(0, 99) < 50, 1'($urandom), PC_W'($urandom), PC_W'($urandom));
        end
        repeat (DEPTH + 1) idle();
    endtask

    task automatic test_reset_midop();
        step(1, 1, 9'h011, 9'h033, 1, 1, 9'h012, 9'h034);
        step(1, 0, 9'h013, 9'h035, 1, 1, 9'h014, 9'h036);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({bus.wr_en, bus.init_busy, bus.q_full} !== 3'b010) begin
            miscompares++; $display("FAIL midop_reset got en=%b busy=%b full=%b exp 0 1 0", bus.wr_en, bus.init_busy, bus.q_full);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NENT; i++) idle();
        for (int i = 0; i < 5; i++) begin
            idle();
            vectors++;
            if (bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL midop_stale got wr_en=%b idx=%h exp 0", bus.wr_en, bus.wr_index); end
        end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_single();
        test_dual();
        test_fill();
        test_random();
        test_init_enqueue();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
